// File: rtl/ram_sdp_clr.sv
// Simple dual-port synchronous RAM with byte-enabled writes, a 1- or 2-cycle
// read pipeline with valid strobe, and a clear sequencer that zeroes the
// whole array after reset and on command.
module ram_sdp_clr #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wbe,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata,
  output logic                rvalid,
  input  logic                clr,
  output logic                busy,
  output logic                clr_done
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned NBYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  state_e            state;
  state_e            state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_nxt;
  logic              busy_nxt;
  logic              clr_done_nxt;
  logic              clr_wr_c;
  logic              wr_en_c;
  logic              rd_en_c;
  logic [DATA_W-1:0] wr_word_c;
  logic [DATA_W-1:0] rd_word_c;

  logic [DATA_W-1:0] mem [DEPTH];

  // State, clear counter and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      cnt      <= '0;
      busy     <= 1'b1;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      busy     <= busy_nxt;
      clr_done <= clr_done_nxt;
    end
  end

  // Next state: sweep the array once, then wait for a clear command
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_CLEAR: begin
        cnt_nxt = cnt + ADDR_W'(1);
        if (cnt == LAST_ADDR) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (clr) begin
          state_nxt = ST_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs and access enables; clr beats a same-cycle write but not a read
  always_comb begin
    clr_wr_c     = 1'b0;
    wr_en_c      = 1'b0;
    rd_en_c      = 1'b0;
    clr_done_nxt = 1'b0;
    busy_nxt     = (state_nxt == ST_CLEAR);
    case (state)
      ST_CLEAR: begin
        clr_wr_c     = 1'b1;
        clr_done_nxt = (cnt == LAST_ADDR);
      end
      ST_IDLE: begin
        wr_en_c = we && !clr;
        rd_en_c = re;
      end
      default: begin
        clr_wr_c = 1'b0;
      end
    endcase
  end

  // Byte-merged write word: new bytes where enabled, stored bytes elsewhere
  always_comb begin
    wr_word_c = mem[waddr];
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (wbe[i]) begin
        wr_word_c[8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // Read word, forwarding the merged write on a same-address collision in write-first mode
  always_comb begin
    rd_word_c = mem[raddr];
    if ((RDW_MODE == 1) && wr_en_c && (waddr == raddr)) begin
      rd_word_c = wr_word_c;
    end
  end

  // Array update: clear sweep has the port while busy
  always_ff @(posedge clk) begin
    if (clr_wr_c) begin
      mem[cnt] <= '0;
    end else if (wr_en_c) begin
      mem[waddr] <= wr_word_c;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              s1_v;
    logic [DATA_W-1:0] s1_d;

    // Two-stage read pipeline; data registers only load on valid reads
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_v   <= 1'b0;
        s1_d   <= '0;
        rvalid <= 1'b0;
        rdata  <= '0;
      end else begin
        s1_v   <= rd_en_c;
        rvalid <= s1_v;
        if (rd_en_c) begin
          s1_d <= rd_word_c;
        end
        if (s1_v) begin
          rdata <= s1_d;
        end
      end
    end
  end else begin : g_lat1
    // Single-stage read; rdata holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rvalid <= 1'b0;
        rdata  <= '0;
      end else begin
        rvalid <= rd_en_c;
        if (rd_en_c) begin
          rdata <= rd_word_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Directed bench for ram_sdp_clr: a read-first/latency-1 instance and a
// write-first/latency-2 instance share all inputs and are checked each cycle.
module tb_ram_sdp_clr;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic [1:0]  wbe;
  logic        re;
  logic [3:0]  raddr;
  logic        clr;

  logic [15:0] rdata1, rdata2;
  logic        rvalid1, rvalid2;
  logic        busy1, busy2;
  logic        done1, done2;

  int n_checks;
  int n_errors;

  // Expected read presented by the latency-2 instance one cycle later
  logic        prev_v;
  logic [15:0] prev_d;

  ram_sdp_clr #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1),
    .clr(clr), .busy(busy1), .clr_done(done1)
  );

  ram_sdp_clr #(.DATA_W(16), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
    .re(re), .raddr(raddr), .rdata(rdata2), .rvalid(rvalid2),
    .clr(clr), .busy(busy2), .clr_done(done2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, step past the edge, check both read ports
  task automatic op(input logic i_we, input logic [3:0] i_wa, input logic [15:0] i_wd,
                    input logic [1:0] i_be, input logic i_re, input logic [3:0] i_ra,
                    input logic i_clr, input logic acc, input logic [15:0] e1,
                    input logic [15:0] e2);
    we    = i_we;
    waddr = i_wa;
    wdata = i_wd;
    wbe   = i_be;
    re    = i_re;
    raddr = i_ra;
    clr   = i_clr;
    @(posedge clk);
    #1;
    check("rvalid_l1", 32'(rvalid1), 32'(acc));
    if (acc) check("rdata_l1", 32'(rdata1), 32'(e1));
    check("rvalid_l2", 32'(rvalid2), 32'(prev_v));
    if (prev_v) check("rdata_l2", 32'(rdata2), 32'(prev_d));
    prev_v = acc;
    prev_d = e2;
  endtask

  task automatic idle();
    op(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] be);
    op(1'b1, a, d, be, 1'b0, 4'd0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic rd(input logic [3:0] a, input logic [15:0] e1, input logic [15:0] e2);
    op(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, a, 1'b0, 1'b1, e1, e2);
  endtask

  // 15 more busy cycles, then busy falls with a single clr_done pulse
  task automatic clear_window(input logic poke);
    for (int i = 0; i < 15; i++) begin
      if (poke) op(1'b1, 4'd2, 16'hDEAD, 2'b11, 1'b1, 4'd2, 1'b1, 1'b0, 16'h0000, 16'h0000);
      else idle();
      check("busy_l1", 32'(busy1), 32'd1);
      check("busy_l2", 32'(busy2), 32'd1);
      check("done_early", 32'(done1), 32'd0);
    end
    if (poke) op(1'b1, 4'd2, 16'hDEAD, 2'b11, 1'b1, 4'd2, 1'b0, 1'b0, 16'h0000, 16'h0000);
    else idle();
    check("busy_end_l1", 32'(busy1), 32'd0);
    check("busy_end_l2", 32'(busy2), 32'd0);
    check("done_l1", 32'(done1), 32'd1);
    check("done_l2", 32'(done2), 32'd1);
    idle();
    check("done_pulse", 32'(done1), 32'd0);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 16; i++) rd(4'(i), 16'h0000, 16'h0000);
    idle();
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    prev_v   = 1'b0;
    prev_d   = 16'h0000;
    rst_n    = 1'b0;
    we       = 1'b0;
    waddr    = 4'd0;
    wdata    = 16'h0000;
    wbe      = 2'b00;
    re       = 1'b0;
    raddr    = 4'd0;
    clr      = 1'b0;

    // Reset state and auto-clear
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy1), 32'd1);
    check("rst_done", 32'(done1), 32'd0);
    check("rst_rvalid_l1", 32'(rvalid1), 32'd0);
    check("rst_rvalid_l2", 32'(rvalid2), 32'd0);
    check("rst_rdata_l1", 32'(rdata1), 32'd0);
    check("rst_rdata_l2", 32'(rdata2), 32'd0);
    rst_n = 1'b1;
    clear_window(1'b0);
    read_all_zero();

    // Byte enables
    wr(4'd0, 16'h1122, 2'b11);
    wr(4'd0, 16'hAABB, 2'b01);
    rd(4'd0, 16'h11BB, 16'h11BB);
    idle();

    // Back-to-back reads
    wr(4'd1, 16'h0101, 2'b11);
    wr(4'd2, 16'h0202, 2'b11);
    wr(4'd3, 16'h0303, 2'b11);
    rd(4'd1, 16'h0101, 16'h0101);
    rd(4'd2, 16'h0202, 16'h0202);
    rd(4'd3, 16'h0303, 16'h0303);
    idle();
    check("rdata_hold_l1", 32'(rdata1), 32'h0303);
    idle();

    // Read-during-write, same and different address
    wr(4'd5, 16'h5555, 2'b11);
    op(1'b1, 4'd5, 16'hABCD, 2'b10, 1'b1, 4'd5, 1'b0, 1'b1, 16'h5555, 16'hAB55);
    rd(4'd5, 16'hAB55, 16'hAB55);
    op(1'b1, 4'd6, 16'h6666, 2'b11, 1'b1, 4'd1, 1'b0, 1'b1, 16'h0101, 16'h0101);
    rd(4'd6, 16'h6666, 16'h6666);
    idle();
    idle();

    // Clear command with a colliding write (dropped) and read (accepted)
    op(1'b1, 4'd7, 16'h7777, 2'b11, 1'b1, 4'd1, 1'b1, 1'b1, 16'h0101, 16'h0101);
    check("clr_busy", 32'(busy1), 32'd1);
    clear_window(1'b1);
    read_all_zero();

    // Reset in the middle of a clear sweep
    op(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b1, 1'b0, 16'h0000, 16'h0000);
    repeat (9) idle();
    rst_n  = 1'b0;
    prev_v = 1'b0;
    idle();
    check("midrst_busy", 32'(busy1), 32'd1);
    rst_n = 1'b1;
    clear_window(1'b0);
    rd(4'd5, 16'h0000, 16'h0000);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
